// File: rtl/write_back_unit.sv
// write_back_unit
//
// Purpose:
//   Handles the sequencer's write-back step. A one-cycle start pulse latches
//   the layer opcode and the conv-type flag. The unit then drains N_WORDS
//   signed accumulators from the convolution result buffer. Each word is
//   ReLU'd, round-shifted right by SHIFT and saturated to DATA_W bits. The
//   result goes to feature memory through a ready-gated write port. A
//   one-cycle finish pulse closes the step.
//
// Ports:
//   i_clk              clock
//   i_reset            synchronous active-low reset
//   i_startWriteBack   one-cycle start pulse (honoured only when idle)
//   i_opcode           layer opcode, sampled with start
//   i_opConv           conv type, sampled with start (selects BASE1/BASE0)
//   o_finish_writeBack one-cycle done pulse
//   o_busy             high from the cycle after start until finish inclusive
//   o_rdAddr           result buffer read index (holds outside READ)
//   i_rdData           result buffer data, valid the cycle after READ
//   o_memWrEn          feature memory write request
//   o_memAddr          feature memory write address
//   o_memData          feature memory write data
//   i_memReady         write accepted when o_memWrEn & i_memReady

module write_back_unit #(
    parameter int                DATA_W  = 8,
    parameter int                ACC_W   = 32,
    parameter int                ADDR_W  = 16,
    parameter int                N_WORDS = 64,
    parameter int                IDX_W   = 6,
    parameter int                SHIFT   = 8,
    parameter logic [ADDR_W-1:0] BASE0   = 16'h0000,
    parameter logic [ADDR_W-1:0] BASE1   = 16'h4000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_startWriteBack,
    input  logic [5:0]        i_opcode,
    input  logic              i_opConv,
    output logic              o_finish_writeBack,
    output logic              o_busy,
    output logic [IDX_W-1:0]  o_rdAddr,
    input  logic [ACC_W-1:0]  i_rdData,
    output logic              o_memWrEn,
    output logic [ADDR_W-1:0] o_memAddr,
    output logic [DATA_W-1:0] o_memData,
    input  logic              i_memReady
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } state_t;

    // Half an LSB of the shifted result, added before the shift to round to nearest.
    localparam logic [ACC_W:0] ROUND_BIAS = (ACC_W+1)'(2 ** (SHIFT - 1));

    state_t            state_q,   state_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic [5:0]        opcode_q,  opcode_d;
    logic              opConv_q,  opConv_d;
    logic [IDX_W-1:0]  rdAddr_q,  rdAddr_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memData_q, memData_d;

    logic [ACC_W:0]    rounded;
    logic [ACC_W:0]    shifted;
    logic              nonPositive;
    logic [DATA_W-1:0] result;
    logic [ADDR_W-1:0] regionBase;
    logic [ADDR_W-1:0] addrSum;

    // Requantisation of the word arriving from the result buffer. The extra
    // top bit keeps the rounding add from overflowing. Any set bit above
    // DATA_W after the shift means the value saturates to all ones.
    assign rounded     = {1'b0, i_rdData} + ROUND_BIAS;
    assign shifted     = rounded >> SHIFT;
    assign nonPositive = i_rdData[ACC_W-1] || (i_rdData == '0);
    assign result      = nonPositive              ? '0 :
                         (|shifted[ACC_W:DATA_W]) ? '1 :
                                                    shifted[DATA_W-1:0];

    // Destination is base + opcode*N_WORDS + index. N_WORDS is a power of
    // two, so the multiply is a shift. The sum wraps modulo 2^ADDR_W.
    assign regionBase = opConv_q ? BASE1 : BASE0;
    assign addrSum    = regionBase + (ADDR_W'(opcode_q) << IDX_W) + ADDR_W'(idx_q);

    // State and datapath registers. Reset wins in any state, which abandons
    // a partial transfer without a finish pulse.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            opcode_q  <= '0;
            opConv_q  <= 1'b0;
            rdAddr_q  <= '0;
            memAddr_q <= '0;
            memData_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            opcode_q  <= opcode_d;
            opConv_q  <= opConv_d;
            rdAddr_q  <= rdAddr_d;
            memAddr_q <= memAddr_d;
            memData_q <= memData_d;
        end
    end

    // Next-state logic. Start is only looked at in IDLE, so the latched
    // opcode/opConv stay fixed for the whole transfer. The write address and
    // data are registered in WAIT and then held through any WRITE stall.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        opcode_d  = opcode_q;
        opConv_d  = opConv_q;
        rdAddr_d  = rdAddr_q;
        memAddr_d = memAddr_q;
        memData_d = memData_q;
        case (state_q)
            IDLE: begin
                if (i_startWriteBack) begin
                    opcode_d = i_opcode;
                    opConv_d = i_opConv;
                    idx_d    = '0;
                    state_d  = READ;
                end
            end
            READ: begin
                rdAddr_d = idx_q;
                state_d  = WAIT;
            end
            WAIT: begin
                memData_d = result;
                memAddr_d = addrSum;
                state_d   = WRITE;
            end
            WRITE: begin
                if (i_memReady) begin
                    if (idx_q == IDX_W'(N_WORDS - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The buffer index is driven straight from idx_q during READ, so the
    // buffer sees it in that same cycle. Outside READ the last index is held.
    assign o_rdAddr           = (state_q == READ) ? idx_q : rdAddr_q;
    assign o_busy             = (state_q != IDLE);
    assign o_memWrEn          = (state_q == WRITE);
    assign o_finish_writeBack = (state_q == DONE);
    assign o_memAddr          = memAddr_q;
    assign o_memData          = memData_q;

endmodule

// File: tb/tb_write_back_unit.sv
// tb_write_back_unit
//
// Drives two write_back_unit instances with identical control stimulus.
// Both use N_WORDS=4. Unit 0 keeps the default region bases. Unit 1 moves
// BASE1 to 16'hFFFE so its addresses wrap. Each unit reads its own result
// buffer port from a shared buffer array. A reference model in the bench
// predicts every write, the busy/finish behaviour and the reset state.

module tb_write_back_unit;

    localparam int N      = 4;
    localparam int SHIFT  = 8;
    localparam int DATA_W = 8;
    localparam int BUDGET = 300;

    logic        i_clk;
    logic        i_reset;
    logic        i_startWriteBack;
    logic [5:0]  i_opcode;
    logic        i_opConv;
    logic        i_memReady;

    logic        finA, busyA, wrEnA;
    logic [1:0]  rdAddrA;
    logic [15:0] memAddrA;
    logic [7:0]  memDataA;
    logic [31:0] rdDataA;

    logic        finB, busyB, wrEnB;
    logic [1:0]  rdAddrB;
    logic [15:0] memAddrB;
    logic [7:0]  memDataB;
    logic [31:0] rdDataB;

    logic [31:0] bufMem [N];

    int vecCount  = 0;
    int missCount = 0;

    // Reference model state, one slot per unit
    bit          mBusy    [2];
    bit          finDue   [2];
    bit          holdPend [2];
    logic [31:0] holdAddr [2];
    logic [31:0] holdData [2];
    int          wrCnt    [2];
    int          startCyc [2];
    int          finCnt   [2];
    int          finLat   [2];
    int          expAddr  [2][N];
    int          expData  [2][N];
    int          cyc        = 0;
    bit          rstPending = 1'b1;

    write_back_unit #(
        .N_WORDS (4),
        .IDX_W   (2)
    ) dutA (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_startWriteBack   (i_startWriteBack),
        .i_opcode           (i_opcode),
        .i_opConv           (i_opConv),
        .o_finish_writeBack (finA),
        .o_busy             (busyA),
        .o_rdAddr           (rdAddrA),
        .i_rdData           (rdDataA),
        .o_memWrEn          (wrEnA),
        .o_memAddr          (memAddrA),
        .o_memData          (memDataA),
        .i_memReady         (i_memReady)
    );

    write_back_unit #(
        .N_WORDS (4),
        .IDX_W   (2),
        .BASE1   (16'hFFFE)
    ) dutB (
        .i_clk              (i_clk),
        .i_reset            (i_reset),
        .i_startWriteBack   (i_startWriteBack),
        .i_opcode           (i_opcode),
        .i_opConv           (i_opConv),
        .o_finish_writeBack (finB),
        .o_busy             (busyB),
        .o_rdAddr           (rdAddrB),
        .i_rdData           (rdDataB),
        .o_memWrEn          (wrEnB),
        .o_memAddr          (memAddrB),
        .o_memData          (memDataB),
        .i_memReady         (i_memReady)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Result buffer behaves as a synchronous RAM: data follows the address by one cycle
    always @(posedge i_clk) begin
        rdDataA <= bufMem[rdAddrA];
        rdDataB <= bufMem[rdAddrB];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // ReLU, round to nearest on the shift, saturate to DATA_W bits
    function automatic int quantRef(input logic [31:0] raw);
        longint acc;
        longint r;
        acc = longint'(signed'(raw));
        if (acc <= 0) return 0;
        r = (acc + longint'(2 ** (SHIFT - 1))) / longint'(2 ** SHIFT);
        if (r > longint'(2 ** DATA_W - 1)) return 2 ** DATA_W - 1;
        return int'(r);
    endfunction

    function automatic logic [31:0] pickAcc();
        case ($urandom_range(0, 4))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 300));
            2:       return 32'($urandom_range(65000, 66000));
            3:       return -32'($urandom_range(0, 1000));
            default: return 32'($urandom_range(0, 40000));
        endcase
    endfunction

    // Compares one unit's outputs for the current cycle, then advances its
    // model to account for what the coming clock edge will do.
    task automatic checkUnit(input int u, input logic fin, input logic busy, input logic [1:0] rdA,
                             input logic wrEn, input logic [15:0] addr, input logic [7:0] data);
        string p;
        int    base1;
        p     = (u == 0) ? "u0" : "u1";
        base1 = (u == 0) ? 32'h4000 : 32'hFFFE;
        if (rstPending) begin
            checkOutput({p, ".rstBusy"},   32'(busy), 0);
            checkOutput({p, ".rstFinish"}, 32'(fin),  0);
            checkOutput({p, ".rstWrEn"},   32'(wrEn), 0);
            checkOutput({p, ".rstAddr"},   32'(addr), 0);
            checkOutput({p, ".rstData"},   32'(data), 0);
            checkOutput({p, ".rstRdAddr"}, 32'(rdA),  0);
        end else begin
            checkOutput({p, ".busy"},   32'(busy), 32'(mBusy[u]));
            checkOutput({p, ".finish"}, 32'(fin),  32'(finDue[u]));
            if (!mBusy[u] || finDue[u]) checkOutput({p, ".wrEnIdle"}, 32'(wrEn), 0);
            if (holdPend[u]) begin
                checkOutput({p, ".holdWrEn"}, 32'(wrEn), 1);
                checkOutput({p, ".holdAddr"}, 32'(addr), holdAddr[u]);
                checkOutput({p, ".holdData"}, 32'(data), holdData[u]);
            end
        end
        if (fin) begin
            finCnt[u]++;
            finLat[u] = cyc - startCyc[u];
        end
        holdPend[u] = 1'b0;
        if (!i_reset) begin
            mBusy[u]  = 1'b0;
            finDue[u] = 1'b0;
            wrCnt[u]  = 0;
        end else if (finDue[u]) begin
            finDue[u] = 1'b0;
            mBusy[u]  = 1'b0;
        end else if (mBusy[u]) begin
            if (wrEn && i_memReady) begin
                if (wrCnt[u] < N) begin
                    checkOutput({p, ".wrAddr"}, 32'(addr), 32'(expAddr[u][wrCnt[u]]));
                    checkOutput({p, ".wrData"}, 32'(data), 32'(expData[u][wrCnt[u]]));
                end
                wrCnt[u]++;
                if (wrCnt[u] == N) finDue[u] = 1'b1;
            end else if (wrEn) begin
                holdPend[u] = 1'b1;
                holdAddr[u] = 32'(addr);
                holdData[u] = 32'(data);
            end
        end else if (i_startWriteBack) begin
            mBusy[u]    = 1'b1;
            wrCnt[u]    = 0;
            startCyc[u] = cyc;
            for (int k = 0; k < N; k++) begin
                expAddr[u][k] = ((i_opConv ? base1 : 0) + int'(i_opcode) * N + k) & 32'hFFFF;
                expData[u][k] = quantRef(bufMem[k]);
            end
        end
    endtask

    task automatic monitorCycle();
        cyc++;
        checkUnit(0, finA, busyA, rdAddrA, wrEnA, memAddrA, memDataA);
        checkUnit(1, finB, busyB, rdAddrB, wrEnB, memAddrB, memDataB);
        rstPending = !i_reset;
    endtask

    // Samples the current cycle at the falling edge, then moves to just after the next rising edge
    task automatic nextCycle();
        @(negedge i_clk);
        monitorCycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic loadBuf(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] v3);
        bufMem[0] = v0;
        bufMem[1] = v1;
        bufMem[2] = v2;
        bufMem[3] = v3;
    endtask

    // One transfer. Start is driven in cycle 0, and the run ends at the first
    // cycle where both models are idle again. That lets the next call start
    // in the cycle right after DONE.
    //   stallAt/stallLen : ready held low over that cycle window
    //   rstAt            : cycle with reset low (-1 = none)
    //   rndReady         : random ready instead of a window
    //   extra            : extra starts in READ, WRITE and DONE, with a different opcode/opConv
    //   expLat           : required finish cycle (0 = not checked)
    //   expFin           : required number of finish pulses
    task automatic applyStimulus(input int opc, input bit conv, input int stallAt, input int stallLen,
                                 input int rstAt, input bit rndReady, input bit extra,
                                 input int expLat, input int expFin);
        int k;
        bit done;
        finCnt[0] = 0;
        finCnt[1] = 0;
        finLat[0] = 0;
        finLat[1] = 0;
        i_opcode         = 6'(opc);
        i_opConv         = conv;
        i_startWriteBack = 1'b1;
        i_memReady       = 1'b1;
        i_reset          = 1'b1;
        nextCycle();
        k    = 1;
        done = 1'b0;
        while (!done) begin
            if (k > BUDGET) begin
                checkOutput("cycleBudget", 32'(k), 32'(BUDGET));
                done = 1'b1;
            end else if (!mBusy[0] && !mBusy[1]) begin
                done = 1'b1;
            end else begin
                i_startWriteBack = extra && (k == 1 || k == 3 || k == 3 * N + 1);
                i_opcode         = extra ? 6'(opc ^ 5) : 6'(opc);
                i_opConv         = extra ? !conv : conv;
                i_memReady       = rndReady ? ($urandom_range(0, 3) != 0) : !(k >= stallAt && k < stallAt + stallLen);
                i_reset          = !(k == rstAt);
                nextCycle();
                k++;
            end
        end
        i_startWriteBack = 1'b0;
        i_reset          = 1'b1;
        i_memReady       = 1'b1;
        checkOutput("u0.finCount", 32'(finCnt[0]), 32'(expFin));
        checkOutput("u1.finCount", 32'(finCnt[1]), 32'(expFin));
        if (expLat > 0) begin
            checkOutput("u0.finCycle", 32'(finLat[0]), 32'(expLat));
            checkOutput("u1.finCycle", 32'(finLat[1]), 32'(expLat));
        end
    endtask

    initial begin
        i_reset          = 1'b0;
        i_startWriteBack = 1'b0;
        i_opcode         = '0;
        i_opConv         = 1'b0;
        i_memReady       = 1'b1;
        for (int u = 0; u < 2; u++) begin
            mBusy[u]    = 1'b0;
            finDue[u]   = 1'b0;
            holdPend[u] = 1'b0;
            wrCnt[u]    = 0;
            startCyc[u] = 0;
        end
        loadBuf(0, 0, 0, 0);
        nextCycle();
        nextCycle();
        i_reset = 1'b1;
        nextCycle();

        $display("[TB] basic transfer, opcode 3");
        loadBuf(32'd1000, -32'sd50, 32'd70000, 32'd128);
        applyStimulus(3, 1'b0, 0, 0, -1, 1'b0, 1'b0, 13, 1);

        $display("[TB] conv region and rounding boundaries");
        loadBuf(32'd127, 32'd128, 32'd65407, 32'd65408);
        applyStimulus(20, 1'b1, 0, 0, -1, 1'b0, 1'b0, 13, 1);

        $display("[TB] backpressure on word 1");
        loadBuf(32'd300, 32'd5000, -32'sd1, 32'd0);
        applyStimulus(7, 1'b0, 6, 5, -1, 1'b0, 1'b0, 18, 1);

        $display("[TB] extra start pulses, then back-to-back start");
        loadBuf(32'd256, 32'd383, 32'd384, 32'h7FFF_FFFF);
        applyStimulus(9, 1'b1, 0, 0, -1, 1'b0, 1'b1, 13, 1);
        loadBuf(32'd640, 32'd1, 32'h8000_0000, 32'd65279);
        applyStimulus(33, 1'b0, 0, 0, -1, 1'b0, 1'b0, 13, 1);

        $display("[TB] reset during WRITE of word 2");
        loadBuf(32'd2000, 32'd3000, 32'd4000, 32'd5000);
        applyStimulus(5, 1'b1, 0, 0, 9, 1'b0, 1'b0, 0, 0);
        loadBuf(32'd1500, 32'd2500, 32'd3500, 32'd4500);
        applyStimulus(6, 1'b0, 0, 0, -1, 1'b0, 1'b0, 13, 1);

        $display("[TB] address wrap in high region");
        loadBuf(32'd129, 32'd1000000, -32'sd7, 32'd255);
        applyStimulus(0, 1'b1, 0, 0, -1, 1'b0, 1'b0, 13, 1);

        $display("[TB] randomized transfers with random ready");
        for (int t = 0; t < 30; t++) begin
            loadBuf(pickAcc(), pickAcc(), pickAcc(), pickAcc());
            applyStimulus(int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 0, 0, -1, 1'b1, 1'b0, 0, 1);
            if ($urandom_range(0, 2) == 0) nextCycle();
        end
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
